// File: rtl/aquarius_kbd_pkg.sv
// rtl/aquarius_kbd_pkg.sv - shared types and constants for the Aquarius PS/2 keyboard matrix
package aquarius_kbd_pkg;

    // Matrix geometry as seen by the Z80 keyboard port
    localparam int NCOL = 8;
    localparam int NROW = 6;

    // PS/2 set-2 prefix and control bytes
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;

    // Left/right shift codes; after E0 they are the keyboard's fake shifts
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_SKIP
    } kbd_state_e;

    typedef struct packed {
        logic [2:0] col;
        logic [2:0] row;
    } key_pos_t;

    typedef logic [NCOL-1:0][NROW-1:0] kbd_matrix_t;

    function automatic key_pos_t key_pos(input logic [2:0] col, input logic [2:0] row);
        key_pos_t p;
        p.col = col;
        p.row = row;
        return p;
    endfunction

    // Named keys that need special handling or are referenced from several places
    localparam key_pos_t KEY_RTN   = key_pos(3'd0, 3'd1);
    localparam key_pos_t KEY_BS    = key_pos(3'd0, 3'd4);
    localparam key_pos_t KEY_A     = key_pos(3'd6, 3'd4);
    localparam key_pos_t KEY_SPACE = key_pos(3'd6, 3'd5);
    localparam key_pos_t KEY_SHIFT = key_pos(3'd7, 3'd0);
    localparam key_pos_t KEY_CTRL  = key_pos(3'd7, 3'd5);

endpackage

// File: rtl/aquarius_kbd_map.sv
// rtl/aquarius_kbd_map.sv - combinational PS/2 set-2 scan code to Aquarius matrix position ROM
module aquarius_kbd_map
    import aquarius_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [2:0] col,
    output logic [2:0] row
);

    key_pos_t pos;

    assign col = pos.col;
    assign row = pos.row;

    // Scan-code ROM; anything not listed is reported as a miss
    always_comb begin
        hit = 1'b1;
        pos = KEY_A;
        if (ext) begin
            case (code)
                8'h5A:   pos = KEY_RTN;              // keypad enter
                8'h14:   pos = KEY_CTRL;             // right ctrl
                8'h71:   pos = KEY_BS;               // delete
                8'h4A:   pos = key_pos(3'd1, 3'd1);  // keypad slash
                default: hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h55:   pos = key_pos(3'd0, 3'd0);  // =
                8'h4C:   pos = key_pos(3'd0, 3'd2);  // ;
                8'h49:   pos = key_pos(3'd0, 3'd3);  // .
                8'h66:   pos = KEY_BS;
                8'h52:   pos = key_pos(3'd0, 3'd5);  // quote as colon
                8'h4E:   pos = key_pos(3'd1, 3'd0);  // -
                8'h4A:   pos = key_pos(3'd1, 3'd1);  // /
                8'h45:   pos = key_pos(3'd1, 3'd2);  // 0
                8'h4D:   pos = key_pos(3'd1, 3'd3);  // P
                8'h4B:   pos = key_pos(3'd1, 3'd4);  // L
                8'h41:   pos = key_pos(3'd1, 3'd5);  // ,
                8'h46:   pos = key_pos(3'd2, 3'd0);  // 9
                8'h44:   pos = key_pos(3'd2, 3'd1);  // O
                8'h42:   pos = key_pos(3'd2, 3'd2);  // K
                8'h3A:   pos = key_pos(3'd2, 3'd3);  // M
                8'h31:   pos = key_pos(3'd2, 3'd4);  // N
                8'h3B:   pos = key_pos(3'd2, 3'd5);  // J
                8'h3E:   pos = key_pos(3'd3, 3'd0);  // 8
                8'h43:   pos = key_pos(3'd3, 3'd1);  // I
                8'h3D:   pos = key_pos(3'd3, 3'd2);  // 7
                8'h3C:   pos = key_pos(3'd3, 3'd3);  // U
                8'h33:   pos = key_pos(3'd3, 3'd4);  // H
                8'h32:   pos = key_pos(3'd3, 3'd5);  // B
                8'h36:   pos = key_pos(3'd4, 3'd0);  // 6
                8'h35:   pos = key_pos(3'd4, 3'd1);  // Y
                8'h34:   pos = key_pos(3'd4, 3'd2);  // G
                8'h2A:   pos = key_pos(3'd4, 3'd3);  // V
                8'h21:   pos = key_pos(3'd4, 3'd4);  // C
                8'h2B:   pos = key_pos(3'd4, 3'd5);  // F
                8'h2E:   pos = key_pos(3'd5, 3'd0);  // 5
                8'h2C:   pos = key_pos(3'd5, 3'd1);  // T
                8'h25:   pos = key_pos(3'd5, 3'd2);  // 4
                8'h2D:   pos = key_pos(3'd5, 3'd3);  // R
                8'h23:   pos = key_pos(3'd5, 3'd4);  // D
                8'h22:   pos = key_pos(3'd5, 3'd5);  // X
                8'h26:   pos = key_pos(3'd6, 3'd0);  // 3
                8'h24:   pos = key_pos(3'd6, 3'd1);  // E
                8'h1B:   pos = key_pos(3'd6, 3'd2);  // S
                8'h1A:   pos = key_pos(3'd6, 3'd3);  // Z
                8'h1C:   pos = KEY_A;
                8'h29:   pos = KEY_SPACE;
                8'h12:   pos = KEY_SHIFT;            // left shift
                8'h59:   pos = KEY_SHIFT;            // right shift
                8'h1D:   pos = key_pos(3'd7, 3'd1);  // W
                8'h16:   pos = key_pos(3'd7, 3'd2);  // 1
                8'h15:   pos = key_pos(3'd7, 3'd3);  // Q
                8'h1E:   pos = key_pos(3'd7, 3'd4);  // 2
                8'h14:   pos = KEY_CTRL;             // left ctrl
                default: hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/aquarius_kbd_matrix.sv
// rtl/aquarius_kbd_matrix.sv - PS/2 byte sequencer maintaining the Aquarius 8x6 key matrix
module aquarius_kbd_matrix
    import aquarius_kbd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
    parameter logic [2:0]  PAUSE_SKIP  = 3'd7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    input  logic       ps2_error,
    input  logic [7:0] col_sel_n,
    output logic [5:0] rows_n,
    output logic       any_key,
    output logic       key_event
);

    kbd_state_e  state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic [2:0]  skip_q, skip_d;
    kbd_matrix_t matrix_q, matrix_d;
    logic [5:0]  rows_n_q, rows_n_d;
    logic        any_key_q, any_key_d;
    logic        key_event_q, key_event_d;

    logic        map_ext;
    logic        map_hit;
    logic [2:0]  map_col;
    logic [2:0]  map_row;
    logic        do_make;
    logic        do_break;
    logic        do_clear;

    // The ROM is consulted with the byte currently on the bus; the prefix state decides ext
    assign map_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

    aquarius_kbd_map u_map (
        .ext  (map_ext),
        .code (ps2_byte),
        .hit  (map_hit),
        .col  (map_col),
        .row  (map_row)
    );

    // Prefix sequencer: next state, timeout/skip counters and which matrix action to take
    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        skip_d   = skip_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        do_clear = 1'b0;
        if (ps2_error) begin
            // A corrupted byte makes any half-received sequence meaningless
            state_d = ST_IDLE;
            tmo_d   = '0;
            skip_d  = '0;
        end else if (ps2_valid) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    case (ps2_byte)
                        PS2_BRK:   state_d = ST_BRK;
                        PS2_EXT:   state_d = ST_EXT;
                        PS2_PAUSE: begin
                            state_d = ST_SKIP;
                            skip_d  = PAUSE_SKIP;
                        end
                        PS2_BAT:   do_clear = 1'b1;
                        default:   do_make  = 1'b1;
                    endcase
                end
                ST_BRK: begin
                    do_break = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT: begin
                    if (ps2_byte == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        // E0 12 / E0 59 are fake shifts wrapped around nav keys
                        do_make = (ps2_byte != PS2_LSHIFT) && (ps2_byte != PS2_RSHIFT);
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    do_break = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_SKIP: begin
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q >= TIMEOUT_CYC - 16'd1) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                skip_d  = '0;
            end else if (tmo_q != 16'hFFFF) begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Matrix write for make/break/self-test clear; key_event flags a real bit change
    always_comb begin
        matrix_d = matrix_q;
        if (do_clear) begin
            matrix_d = '0;
        end else if (map_hit && do_make) begin
            matrix_d[map_col][map_row] = 1'b1;
        end else if (map_hit && do_break) begin
            matrix_d[map_col][map_row] = 1'b0;
        end
        key_event_d = (matrix_d != matrix_q);
    end

    // CPU read path: OR selected columns, invert to active-low rows; any_key summary
    always_comb begin
        rows_n_d = '1;
        for (int c = 0; c < NCOL; c++) begin
            if (!col_sel_n[c]) begin
                rows_n_d = rows_n_d & ~matrix_q[c];
            end
        end
        any_key_d = |matrix_q;
    end

    // State, counters, matrix and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            skip_q      <= '0;
            matrix_q    <= '0;
            rows_n_q    <= 6'h3F;
            any_key_q   <= 1'b0;
            key_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            skip_q      <= skip_d;
            matrix_q    <= matrix_d;
            rows_n_q    <= rows_n_d;
            any_key_q   <= any_key_d;
            key_event_q <= key_event_d;
        end
    end

    assign rows_n    = rows_n_q;
    assign any_key   = any_key_q;
    assign key_event = key_event_q;

endmodule

// File: tb/tb_aquarius_kbd_matrix.sv
// tb/tb_aquarius_kbd_matrix.sv - self-checking bench for aquarius_kbd_matrix
module tb_aquarius_kbd_matrix;

    localparam logic [15:0] TMO = 16'd200;

    // Matrix bit index = col*6 + row
    localparam int IDX_A     = 6 * 6 + 4;
    localparam int IDX_RTN   = 0 * 6 + 1;
    localparam int IDX_SHIFT = 7 * 6 + 0;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ps2_byte;
    logic       ps2_valid;
    logic       ps2_error;
    logic [7:0] col_sel_n;
    logic [5:0] rows_n;
    logic       any_key;
    logic       key_event;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ev_cnt   = 0;
    int          exp_ev   = 0;
    logic [47:0] mdl      = '0;

    aquarius_kbd_matrix #(.TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_byte  (ps2_byte),
        .ps2_valid (ps2_valid),
        .ps2_error (ps2_error),
        .col_sel_n (col_sel_n),
        .rows_n    (rows_n),
        .any_key   (any_key),
        .key_event (key_event)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event === 1'b1) ev_cnt <= ev_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_rows(input logic [7:0] sel);
        logic [5:0] r;
        r = 6'h3F;
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 6; k++)
                if (!sel[c] && mdl[c * 6 + k]) r[k] = 1'b0;
        return r;
    endfunction

    task automatic set_bit(input int idx, input bit v);
        if (mdl[idx] != v) exp_ev++;
        mdl[idx] = v;
    endtask

    // All tasks start and end on a falling edge
    task automatic send(input logic [7:0] b);
        ps2_byte  = b;
        ps2_valid = 1'b1;
        @(negedge clk);
        ps2_valid = 1'b0;
    endtask

    task automatic send_with_err(input logic [7:0] b);
        ps2_byte  = b;
        ps2_valid = 1'b1;
        ps2_error = 1'b1;
        @(negedge clk);
        ps2_valid = 1'b0;
        ps2_error = 1'b0;
    endtask

    task automatic pulse_err();
        ps2_error = 1'b1;
        @(negedge clk);
        ps2_error = 1'b0;
    endtask

    // k: 0=A, 1=left shift, 2=right shift, 3=keypad enter
    task automatic key_op(input int k, input bit make);
        case (k)
            0: begin if (!make) send(8'hF0); send(8'h1C); set_bit(IDX_A, make); end
            1: begin if (!make) send(8'hF0); send(8'h12); set_bit(IDX_SHIFT, make); end
            2: begin if (!make) send(8'hF0); send(8'h59); set_bit(IDX_SHIFT, make); end
            default: begin
                send(8'hE0);
                if (!make) send(8'hF0);
                send(8'h5A);
                set_bit(IDX_RTN, make);
            end
        endcase
    endtask

    task automatic verify(input string tag, input logic [7:0] sel);
        col_sel_n = sel;
        @(negedge clk);
        check({tag, ".rows_n"}, 32'(rows_n), 32'(exp_rows(sel)));
        check({tag, ".any_key"}, 32'(any_key), 32'(|mdl));
        check({tag, ".events"}, 32'(ev_cnt), 32'(exp_ev));
    endtask

    initial begin
        reset_n   = 1'b1;
        ps2_byte  = 8'h00;
        ps2_valid = 1'b0;
        ps2_error = 1'b0;
        col_sel_n = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        check("reset.rows_n", 32'(rows_n), 32'h3F);
        check("reset.any_key", 32'(any_key), 32'h0);
        check("reset.key_event", 32'(key_event), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        verify("idle", 8'h00);

        // Single make then break of A
        send(8'h1C);
        set_bit(IDX_A, 1'b1);
        check("a_make.key_event", 32'(key_event), 32'h1);
        verify("a_make", 8'hBF);
        check("a_make.rows_bf", 32'(rows_n), 32'h2F);
        send(8'hF0);
        send(8'h1C);
        set_bit(IDX_A, 1'b0);
        verify("a_break", 8'hBF);
        check("a_break.rows_bf", 32'(rows_n), 32'h3F);

        // Typematic repeats: shift + A, two events only
        send(8'h12); set_bit(IDX_SHIFT, 1'b1);
        send(8'h1C); set_bit(IDX_A, 1'b1);
        send(8'h1C); set_bit(IDX_A, 1'b1);
        send(8'h1C); set_bit(IDX_A, 1'b1);
        verify("typematic", 8'h3F);
        check("typematic.rows_3f", 32'(rows_n), 32'h2E);
        key_op(1, 1'b0);
        key_op(0, 1'b0);
        verify("typematic_rel", 8'h00);

        // Extended keys and fake shift
        key_op(3, 1'b1);
        verify("kp_enter", 8'hFE);
        check("kp_enter.rows_fe", 32'(rows_n), 32'h3D);
        key_op(3, 1'b0);
        verify("kp_enter_rel", 8'hFE);
        send(8'hE0);
        send(8'h12);
        verify("fake_shift", 8'h00);

        // Pause sequence swallowed, following A is a make
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C); set_bit(IDX_A, 1'b1);
        verify("pause", 8'h00);
        check("pause.rows_00", 32'(rows_n), 32'h2F);

        // Timeout boundary: byte at TMO-1 idle cycles still a break, at TMO a make
        send(8'hF0);
        repeat (int'(TMO) - 1) @(negedge clk);
        send(8'h1C); set_bit(IDX_A, 1'b0);
        verify("tmo_edge", 8'hBF);
        send(8'hF0);
        repeat (int'(TMO)) @(negedge clk);
        send(8'h1C); set_bit(IDX_A, 1'b1);
        verify("tmo_expired", 8'hBF);

        // Error abandons a prefix; error beats a simultaneous valid
        key_op(0, 1'b0);
        send(8'hF0);
        pulse_err();
        send(8'h1C); set_bit(IDX_A, 1'b1);
        verify("err_prefix", 8'hBF);
        send_with_err(8'hF0);
        send(8'h1C); set_bit(IDX_A, 1'b1);
        verify("err_wins", 8'hBF);

        // BAT clears everything held
        key_op(1, 1'b1);
        key_op(3, 1'b1);
        verify("held3", 8'h00);
        send(8'hAA);
        if (mdl != '0) exp_ev++;
        mdl = '0;
        verify("bat", 8'h00);

        // Reset in the middle of an E0 sequence
        key_op(0, 1'b1);
        send(8'hE0);
        reset_n = 1'b0;
        #1;
        check("mid_reset.rows_n", 32'(rows_n), 32'h3F);
        check("mid_reset.any_key", 32'(any_key), 32'h0);
        mdl = '0;
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h5A);
        verify("post_reset_5a", 8'h00);

        // Randomized traffic against the key-level model
        for (int it = 0; it < 80; it++) begin
            int unsigned r;
            logic [7:0]  rb;
            r = $urandom_range(0, 8);
            if (r < 6) begin
                key_op(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            end else if (r == 6) begin
                send(8'hE0);
                send($urandom_range(0, 1) != 0 ? 8'h12 : 8'h59);
            end else if (r == 7) begin
                send(8'hE1);
                for (int j = 0; j < 7; j++) begin
                    rb = 8'($urandom_range(0, 255));
                    send(rb);
                end
            end else begin
                send($urandom_range(0, 1) != 0 ? 8'hF0 : 8'hE0);
                pulse_err();
            end
            rb = 8'($urandom_range(0, 255));
            verify("random", rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aquarius_kbd_matrix.md
Name: aquarius_kbd_matrix

Overview:
- Consumes the PS/2 byte stream from the keyboard decoder: one `byte` bus plus a `valid` strobe held for one `clk`.
- Sequences PS/2 set-2 make/break/prefix traffic and maintains an 8-column x 6-row key matrix in Aquarius format.
- The CPU keyboard port reads this matrix: high address byte selects columns, active-low; the result is active-low rows.
- Sits between `ps2_intf` and the Z80 I/O decode, and replaces raw byte/`int` delivery to the core.

Parameters:
- TIMEOUT_CYC, 16'd50000: clocks allowed in a prefix state without a new byte before abandoning the sequence.
- PAUSE_SKIP, 3'd7: bytes discarded after an E1 prefix.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_byte  in  8  decoded PS/2 byte
- ps2_valid  in  1  one-cycle strobe; `ps2_byte` is valid while high
- ps2_error  in  1  one-cycle strobe; parity/framing error from the decoder
- col_sel_n  in  8  CPU A15..A8; a column is selected when its bit is 0
- rows_n  out  6  active-low row data for the selected columns
- any_key  out  1  high while any matrix bit is set
- key_event  out  1  one-cycle pulse when the matrix changes

Behaviour:
- Reset (async, reset_n=0):
  - matrix cleared; FSM in IDLE; timeout counter and skip counter at 0
  - rows_n=6'h3F, any_key=0, key_event=0
- FSM states: IDLE, BRK, EXT, EXT_BRK, SKIP. Transitions on ps2_valid:
  - IDLE: F0->BRK; E0->EXT; E1->SKIP (skip counter loaded with PAUSE_SKIP); AA->clear matrix, stay IDLE; other -> make lookup (ext=0), stay IDLE.
  - BRK: any byte -> break lookup (ext=0) -> IDLE.
  - EXT: F0->EXT_BRK; 12 or 59 (fake shift) -> ignored -> IDLE; other -> make lookup (ext=1) -> IDLE.
  - EXT_BRK: any byte -> break lookup (ext=1) -> IDLE.
  - SKIP: each byte decrements the counter; reaching 0 -> IDLE. No matrix change.
- Lookup:
  - Combinational map: {ext, code} -> {hit, col[2:0], row[2:0]}.
  - Make sets matrix[col][row]; break clears it. No hit -> ignored.
  - The matrix is updated in the cycle after ps2_valid.
  - key_event pulses in that same cycle only if the bit actually changed.
- ps2_error:
  - Any state -> IDLE, matrix unchanged, skip counter cleared.
  - If error and valid occur in the same cycle, error wins.
- Timeout:
  - The counter runs while the state is not IDLE and resets on every ps2_valid.
  - At TIMEOUT_CYC-1 -> IDLE. Counter is 16 bits, saturates, never wraps.
- Read path:
  - rows_n[r] = NOT(OR over c where col_sel_n[c]==0 of matrix[c][r]). Registered, 1-clk latency.
  - col_sel_n=8'hFF -> rows_n=6'h3F. col_sel_n=8'h00 -> OR of all columns.
- any_key: registered OR of all 48 matrix bits.
- Repeated make of a held key (typematic): no change, no key_event.

Decomposition:
- Package aquarius_kbd_pkg:
  - state enum
  - prefix constants PS2_BRK=8'hF0, PS2_EXT=8'hE0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA
  - matrix geometry constants NCOL=8, NROW=6
  - key position constants, e.g. KEY_A={col 6,row 4}, KEY_RTN={col 0,row 1}, KEY_SHIFT={col 7,row 0}
- One sub-module aquarius_kbd_map: purely combinational scan-code ROM (case statement).
  - E0 5A (keypad enter) maps to KEY_RTN.
  - 12 and 59 (both shifts) map to KEY_SHIFT.

Test Plan:
- Reset then bytes 1C, then col_sel_n=8'hBF -> rows_n=6'h2F one clk later, any_key=1, key_event one pulse. Then F0 1C -> rows_n=6'h3F, any_key=0.
- 12, 1C, 1C, 1C (typematic) -> exactly 2 key_event pulses. col_sel_n=8'h3F (cols 6,7) -> rows_n=6'h2E.
- E0 5A -> RETURN set (col_sel_n=8'hFE gives rows_n=6'h3D). E0 F0 5A clears it. E0 12 -> no change.
- E1 14 77 E1 F0 14 F0 77 then 1C -> only A set. Key_event pulses once.
- Send F0, hold idle TIMEOUT_CYC clocks, then 1C -> A is set (make, not break). Same with ps2_error after F0 -> next 1C is a make.
- Keys held, then AA -> matrix clear. Also: reset_n low mid-sequence (after E0) -> rows_n=6'h3F immediately; next 5A treated as non-extended (unmapped, no change).
